// File: rtl/vld_pkg.sv
// Shared types and constants for the JPEG variable-length bit reader.
package vld_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        FF_REQ = 2'd2,
        MARKER = 2'd3
    } vld_state_t;

    localparam logic [7:0] BYTE_FF      = 8'hFF;
    localparam logic [7:0] BYTE_STUFF   = 8'h00;
    localparam int         MAX_BITS     = 16;
    localparam int         SPR_ADDR_BIT = 1;

    // Requests above MAX_BITS read MAX_BITS bits.
    function automatic logic [4:0] clamp_bits(input logic [4:0] n);
        return (n > 5'(MAX_BITS)) ? 5'(MAX_BITS) : n;
    endfunction

endpackage

// File: rtl/vld_bitbuf.sv
// MSB-first bit buffer: extract the top n bits and append one byte below the
// remaining bits, both in the same cycle if needed.
module vld_bitbuf #(
    parameter int BUF_W = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic [7:0]  app_byte_i,
    input  logic        app_vld_i,
    input  logic [4:0]  ext_n_i,
    input  logic        ext_vld_i,
    output logic [15:0] top_o,
    output logic [5:0]  cnt_o
);

    logic [BUF_W-1:0] r_buf;
    logic [5:0]       r_cnt;

    logic [5:0]       w_n;
    logic [5:0]       w_cnt_ext;
    logic [BUF_W-1:0] w_buf_ext;
    logic [BUF_W-1:0] w_byte_al;

    // Bits below the count are always zero, so an over-long extract pads with
    // zeros and the append can simply OR the byte into place.
    assign w_n       = ext_vld_i ? {1'b0, ext_n_i} : 6'd0;
    assign w_cnt_ext = (r_cnt >= w_n) ? (r_cnt - w_n) : 6'd0;
    assign w_buf_ext = r_buf << w_n;
    assign w_byte_al = {app_byte_i, {(BUF_W-8){1'b0}}} >> w_cnt_ext;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_buf <= '0;
            r_cnt <= 6'd0;
        end else if (app_vld_i) begin
            r_buf <= w_buf_ext | w_byte_al;
            r_cnt <= w_cnt_ext + 6'd8;
        end else begin
            r_buf <= w_buf_ext;
            r_cnt <= w_cnt_ext;
        end
    end

    assign top_o = r_buf[BUF_W-1 -: 16];
    assign cnt_o = r_cnt;

endmodule

// File: rtl/or1200_vld_top.sv
// JPEG bit reader for the OR1200: byte fetch with FF00 destuffing and marker
// detection, a CPU get-bit interlock, and a 2-bit SPR window.
//
//   state  | meaning
//   IDLE   | no request; fetch when buffer has room and no marker seen
//   REQ    | byte load outstanding at vld_addr_o
//   FF_REQ | previous byte was FF; fetching the byte that follows it
//   MARKER | FF + non-zero seen; fetching halted until SPR address write
module or1200_vld_top
    import vld_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0383_c1d0,
    parameter int          BUF_W     = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ack_i,
    input  logic [31:0] dat_i,
    input  logic        get_bit_op_i,
    input  logic [4:0]  num_bits_to_read_i,
    input  logic        spr_cs,
    input  logic        spr_write,
    input  logic [1:0]  spr_addr,
    input  logic [31:0] spr_dat_i,
    output logic [31:0] spr_dat_o,
    output logic        stall_cpu_o,
    output logic [31:0] vld_addr_o,
    output logic [31:0] dat_o,
    output logic        load_byte_o,
    output logic        marker_o
);

    localparam logic [5:0] FETCH_THR = 6'(BUF_W - 8);

    vld_state_t  r_state;
    logic        r_ff_seen;
    logic        r_pending;
    logic [4:0]  r_n;

    logic        w_spr_addr_wr;
    logic        w_ack;
    logic [7:0]  w_byte;
    logic        w_ext;
    logic        w_app;
    logic [7:0]  w_app_byte;
    logic [15:0] w_top;
    logic [5:0]  w_cnt;
    logic        w_unused;

    assign w_spr_addr_wr = spr_cs & spr_write & spr_addr[SPR_ADDR_BIT];
    assign w_ack         = load_byte_o & ack_i & ~w_spr_addr_wr;
    assign w_byte        = dat_i[7:0];
    assign w_ext         = r_pending & ((w_cnt >= {1'b0, r_n}) | marker_o);
    assign w_unused      = &{1'b0, dat_i[31:8], spr_addr[0]};

    always_comb begin
        w_app      = 1'b0;
        w_app_byte = w_byte;
        if (w_ack) begin
            if (r_ff_seen) begin
                if (w_byte == BYTE_STUFF) begin
                    w_app      = 1'b1;
                    w_app_byte = BYTE_FF;
                end
            end else if (w_byte != BYTE_FF) begin
                w_app = 1'b1;
            end
        end
    end

    vld_bitbuf #(.BUF_W(BUF_W)) u_bitbuf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (w_spr_addr_wr),
        .app_byte_i (w_app_byte),
        .app_vld_i  (w_app),
        .ext_n_i    (r_n),
        .ext_vld_i  (w_ext),
        .top_o      (w_top),
        .cnt_o      (w_cnt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            load_byte_o <= 1'b0;
            vld_addr_o  <= BASE_ADDR;
            marker_o    <= 1'b0;
            r_ff_seen   <= 1'b0;
        end else if (w_spr_addr_wr) begin
            r_state     <= IDLE;
            load_byte_o <= 1'b0;
            vld_addr_o  <= spr_dat_i;
            marker_o    <= 1'b0;
            r_ff_seen   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cnt <= FETCH_THR && !marker_o) begin
                        load_byte_o <= 1'b1;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (w_ack) begin
                        load_byte_o <= 1'b0;
                        vld_addr_o  <= vld_addr_o + 32'd1;
                        if (w_byte == BYTE_FF) begin
                            r_ff_seen <= 1'b1;
                            r_state   <= FF_REQ;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                FF_REQ: begin
                    // Entered with the request low so it drops for a cycle.
                    if (!load_byte_o) begin
                        load_byte_o <= 1'b1;
                    end else if (w_ack) begin
                        load_byte_o <= 1'b0;
                        if (w_byte == BYTE_STUFF) begin
                            vld_addr_o <= vld_addr_o + 32'd1;
                            r_ff_seen  <= 1'b0;
                            r_state    <= IDLE;
                        end else begin
                            marker_o   <= 1'b1;
                            vld_addr_o <= vld_addr_o - 32'd1;
                            r_state    <= MARKER;
                        end
                    end
                end
                MARKER: begin
                    load_byte_o <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    load_byte_o <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pending <= 1'b0;
            r_n       <= 5'd0;
            dat_o     <= 32'd0;
        end else if (!r_pending) begin
            if (get_bit_op_i) begin
                r_pending <= 1'b1;
                r_n       <= clamp_bits(num_bits_to_read_i);
            end
        end else if (w_ext) begin
            dat_o     <= {16'd0, w_top >> (5'd16 - r_n)};
            r_pending <= 1'b0;
        end
    end

    assign stall_cpu_o = get_bit_op_i | r_pending;
    assign spr_dat_o   = spr_addr[SPR_ADDR_BIT] ? vld_addr_o
                                                : {25'd0, marker_o, w_cnt};

endmodule

// File: tb/tb_or1200_vld_top.sv
// Self-checking bench for or1200_vld_top: byte-memory responder, scoreboard of
// expected get-bit results, table-driven extraction plus corner sequences.
module tb_or1200_vld_top;

    logic        clk;
    logic        rst_i;
    logic        ack_i;
    logic [31:0] dat_i;
    logic        get_bit_op_i;
    logic [4:0]  num_bits_to_read_i;
    logic        spr_cs;
    logic        spr_write;
    logic [1:0]  spr_addr;
    logic [31:0] spr_dat_i;
    logic [31:0] spr_dat_o;
    logic        stall_cpu_o;
    logic [31:0] vld_addr_o;
    logic [31:0] dat_o;
    logic        load_byte_o;
    logic        marker_o;

    localparam logic [31:0] BASE = 32'h0383_c1d0;

    or1200_vld_top dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .ack_i              (ack_i),
        .dat_i              (dat_i),
        .get_bit_op_i       (get_bit_op_i),
        .num_bits_to_read_i (num_bits_to_read_i),
        .spr_cs             (spr_cs),
        .spr_write          (spr_write),
        .spr_addr           (spr_addr),
        .spr_dat_i          (spr_dat_i),
        .spr_dat_o          (spr_dat_o),
        .stall_cpu_o        (stall_cpu_o),
        .vld_addr_o         (vld_addr_o),
        .dat_o              (dat_o),
        .load_byte_o        (load_byte_o),
        .marker_o           (marker_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem_data [0:1023];
    logic        mem_vld  [0:1023];
    int          ack_delay = 0;
    bit          auto_ack  = 1'b1;
    logic [31:0] sb [$];

    typedef struct {
        logic [4:0]  n;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic put(input int a, input logic [7:0] b);
        mem_data[a] = b;
        mem_vld[a]  = 1'b1;
    endtask

    task automatic spr_wr(input logic [1:0] a, input logic [31:0] d);
        spr_cs = 1'b1; spr_write = 1'b1; spr_addr = a; spr_dat_i = d;
        @(negedge clk);
        spr_cs = 1'b0; spr_write = 1'b0; spr_addr = 2'b00; spr_dat_i = 32'h0;
    endtask

    task automatic spr_rd(input logic [1:0] a, output logic [31:0] d);
        spr_cs = 1'b1; spr_write = 1'b0; spr_addr = a;
        #1;
        d = spr_dat_o;
        spr_cs = 1'b0; spr_addr = 2'b00;
    endtask

    task automatic pop_check(input string name);
        logic [31:0] e;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: scoreboard empty, got %h", name, dat_o);
        end else begin
            e = sb.pop_front();
            check(name, dat_o, e);
        end
    endtask

    task automatic get_bits(input logic [4:0] n, input logic [31:0] exp, input string name);
        int cyc;
        sb.push_back(exp);
        get_bit_op_i = 1'b1;
        num_bits_to_read_i = n;
        @(negedge clk);
        get_bit_op_i = 1'b0;
        cyc = 0;
        #1;
        while (stall_cpu_o === 1'b1 && cyc < 300) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 300) begin
            total++; bad++;
            $display("FAIL %s_timeout: stall still %b after %0d cycles, want 0", name, stall_cpu_o, cyc);
        end
        pop_check(name);
    endtask

    // Byte memory: acknowledges mapped addresses after ack_delay request cycles.
    initial begin : responder
        int wait_c;
        wait_c = 0;
        forever begin
            @(negedge clk);
            if (auto_ack) begin
                ack_i = 1'b0;
                dat_i = 32'h0;
                if (load_byte_o && !rst_i) begin
                    if (wait_c >= ack_delay && vld_addr_o < 32'd1024 && mem_vld[vld_addr_o[9:0]]) begin
                        ack_i  = 1'b1;
                        dat_i  = {24'h5A5A5A, mem_data[vld_addr_o[9:0]]};
                        wait_c = 0;
                    end else begin
                        wait_c++;
                    end
                end else begin
                    wait_c = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] rd;
        int hi_cnt;
        int ack_idx;
        int drop_idx;

        for (int i = 0; i < 1024; i++) begin
            mem_data[i] = 8'h00;
            mem_vld[i]  = 1'b0;
        end
        put(32'h100, 8'hA5); put(32'h101, 8'h3C);
        put(32'h080, 8'hFF); put(32'h081, 8'h00); put(32'h082, 8'h12);
        put(32'h0C0, 8'h12); put(32'h0C1, 8'hFF); put(32'h0C2, 8'hD9);
        put(32'h040, 8'h9A); put(32'h041, 8'h7E);
        put(32'h300, 8'hB1);
        put(32'h200, 8'hDE); put(32'h201, 8'hAD); put(32'h202, 8'hBE); put(32'h203, 8'hEF);
        put(32'h204, 8'h12); put(32'h205, 8'h34); put(32'h206, 8'h56); put(32'h207, 8'h78);

        tbl[0] = '{5'd4,  32'h0000_000D};
        tbl[1] = '{5'd12, 32'h0000_0EAD};
        tbl[2] = '{5'd16, 32'h0000_BEEF};
        tbl[3] = '{5'd0,  32'h0000_0000};
        tbl[4] = '{5'd1,  32'h0000_0000};
        tbl[5] = '{5'd3,  32'h0000_0001};
        tbl[6] = '{5'd31, 32'h0000_2345};
        tbl[7] = '{5'd8,  32'h0000_0067};
        tbl[8] = '{5'd4,  32'h0000_0008};

        rst_i = 1'b1; ack_i = 1'b0; dat_i = 32'h0;
        get_bit_op_i = 1'b0; num_bits_to_read_i = 5'd0;
        spr_cs = 1'b0; spr_write = 1'b0; spr_addr = 2'b00; spr_dat_i = 32'h0;
        repeat (3) @(negedge clk);

        check("rst_dat", dat_o, 32'h0);
        check("rst_load", {31'd0, load_byte_o}, 32'h0);
        check("rst_marker", {31'd0, marker_o}, 32'h0);
        check("rst_addr", vld_addr_o, BASE);
        check("rst_stall", {31'd0, stall_cpu_o}, 32'h0);
        spr_rd(2'b00, rd);
        check("rst_count", rd, 32'h0);
        rst_i = 1'b0;
        repeat (3) @(negedge clk);

        // A5 3C
        spr_wr(2'b10, 32'h100);
        repeat (20) @(negedge clk);
        get_bits(5'd4, 32'hA, "t1_get4");
        get_bits(5'd8, 32'h53, "t1_get8");
        get_bits(5'd4, 32'hC, "t1_get4b");
        check("t1_addr", vld_addr_o, 32'h102);
        spr_rd(2'b00, rd);
        check("t1_count", rd, 32'h0);

        // FF 00 12 : stuffed FF
        @(negedge clk);
        spr_wr(2'b10, 32'h080);
        repeat (20) @(negedge clk);
        spr_rd(2'b00, rd);
        check("t2_count16", rd, 32'h10);
        check("t2_addr", vld_addr_o, 32'h083);
        get_bits(5'd8, 32'hFF, "t2_getFF");
        get_bits(5'd8, 32'h12, "t2_get12");

        // 12 FF D9 : marker
        @(negedge clk);
        spr_wr(2'b10, 32'h0C0);
        repeat (20) @(negedge clk);
        check("t3_marker_early", {31'd0, marker_o}, 32'h1);
        get_bits(5'd8, 32'h12, "t3_get12");
        get_bits(5'd8, 32'h00, "t3_getpad");
        check("t3_marker", {31'd0, marker_o}, 32'h1);
        spr_rd(2'b10, rd);
        check("t3_spr_addr", rd, 32'h0C1);
        spr_rd(2'b00, rd);
        check("t3_spr_stat", rd, 32'h40);
        hi_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (load_byte_o !== 1'b0) hi_cnt++;
        end
        check("t3_no_loads", hi_cnt, 0);

        // Table-driven extraction over DE AD BE EF 12 34 56 78
        @(negedge clk);
        spr_wr(2'b10, 32'h200);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            get_bits(tbl[i].n, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // Slow memory: 16 bits from empty buffer
        @(negedge clk);
        ack_delay = 6;
        spr_wr(2'b10, 32'h040);
        sb.push_back(32'h9A7E);
        get_bit_op_i = 1'b1;
        num_bits_to_read_i = 5'd16;
        @(negedge clk);
        get_bit_op_i = 1'b0;
        ack_idx = -1;
        drop_idx = -1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (stall_cpu_o !== 1'b1) begin
                drop_idx = i;
                break;
            end
            if (ack_i === 1'b1 && dat_i[7:0] == 8'h7E) ack_idx = i;
            @(negedge clk);
        end
        check("t4_ack_seen", {31'd0, ack_idx >= 0}, 32'h1);
        check("t4_stall_release", drop_idx - ack_idx, 2);
        pop_check("t4_dat");
        ack_delay = 0;

        // Extraction and append at the same edge with count=8
        @(negedge clk);
        spr_wr(2'b10, 32'h300);
        repeat (10) @(negedge clk);
        spr_rd(2'b00, rd);
        check("t5_count8", rd, 32'h8);
        check("t5_load", {31'd0, load_byte_o}, 32'h1);
        check("t5_addr", vld_addr_o, 32'h301);
        @(negedge clk);
        auto_ack = 1'b0;
        sb.push_back(32'h16);
        get_bit_op_i = 1'b1;
        num_bits_to_read_i = 5'd5;
        @(negedge clk);
        get_bit_op_i = 1'b0;
        ack_i = 1'b1;
        dat_i = 32'hABCD_002C;
        @(negedge clk);
        ack_i = 1'b0;
        dat_i = 32'h0;
        auto_ack = 1'b1;
        #1;
        check("t5_stall", {31'd0, stall_cpu_o}, 32'h0);
        pop_check("t5_dat");
        spr_rd(2'b00, rd);
        check("t5_count11", rd, 32'd11);
        get_bits(5'd11, 32'h12C, "t5_rest");

        // Ignored write, then reset during an outstanding request
        @(negedge clk);
        spr_wr(2'b10, 32'h3F0);
        spr_wr(2'b00, 32'h500);
        repeat (3) @(negedge clk);
        check("t6_addr0_ignored", vld_addr_o, 32'h3F0);
        check("t6_load_pre", {31'd0, load_byte_o}, 32'h1);
        rst_i = 1'b1;
        @(negedge clk);
        #1;
        check("t6_load", {31'd0, load_byte_o}, 32'h0);
        check("t6_addr", vld_addr_o, BASE);
        check("t6_stall", {31'd0, stall_cpu_o}, 32'h0);
        check("t6_dat", dat_o, 32'h0);
        spr_rd(2'b00, rd);
        check("t6_count", rd, 32'h0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
